npu_tile_scheduler: RTL

Command-driven sequencer that sits in front of `tile_processor` and drives it across a rectangular range of 8x8-grid tiles. The host pushes commands (op code plus tile range) into a small FIFO. The scheduler pops each command, issues one `tile_processor` run per tile in row-major order, and waits for each completion. It reports per-command completion, tile count, and errors (illegal op code, per-tile timeout).

---
 rtl/npu_tile_scheduler_if.sv | 31 +++
 rtl/npu_tile_scheduler.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/npu_tile_scheduler_if.sv
// npu_tile_scheduler_if: host command channel.
// Valid/ready push of {op, row range, column range} into the scheduler.
interface npu_tile_scheduler_if;
   logic       cmd_valid;
   logic       cmd_ready;
   logic [2:0] cmd_op;
   logic [2:0] cmd_i_first;
   logic [2:0] cmd_i_last;
   logic [2:0] cmd_j_first;
   logic [2:0] cmd_j_last;

   modport master (
      output cmd_valid,
      output cmd_op,
      output cmd_i_first,
      output cmd_i_last,
      output cmd_j_first,
      output cmd_j_last,
      input  cmd_ready
   );

   modport slave (
      input  cmd_valid,
      input  cmd_op,
      input  cmd_i_first,
      input  cmd_i_last,
      input  cmd_j_first,
      input  cmd_j_last,
      output cmd_ready
   );
endinterface

// File: rtl/npu_tile_scheduler.sv
// npu_tile_scheduler: command FIFO plus sequencer that walks a tile
// rectangle row-major, one tile_processor run per tile.
module npu_tile_scheduler #(
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 4096
) (
   input  logic                   clk,
   input  logic                   reset,
   npu_tile_scheduler_if.slave    cmd,
   input  logic                   abort,
   output logic                   tp_start,
   output logic [2:0]             tp_op_code,
   output logic [2:0]             tp_tile_i,
   output logic [2:0]             tp_tile_j,
   input  logic                   tp_done,
   output logic                   busy,
   output logic                   cmd_done,
   output logic                   err,
   output logic [1:0]             err_code,
   output logic [6:0]             tiles_done
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [AW:0]   FULL  = (AW + 1)'(FIFO_DEPTH);
   localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT,
      NEXT
   } state_t;

   typedef struct packed {
      logic [2:0] op;
      logic [2:0] i_first;
      logic [2:0] i_last;
      logic [2:0] j_first;
      logic [2:0] j_last;
   } cmd_t;

   cmd_t          mem [FIFO_DEPTH];
   cmd_t          in_cmd;
   cmd_t          head;
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW:0]   count;

   state_t        state_q;
   state_t        state_d;
   logic          push;
   logic          pop;
   logic          pop_ill;
   logic          pop_empty;
   logic          head_ill;
   logic          head_empty;
   logic          complete;
   logic          timeout;
   logic          last_tile;
   logic          done_q;
   logic [TW-1:0] tcnt;
   logic [2:0]    i_last_q;
   logic [2:0]    j_first_q;
   logic [2:0]    j_last_q;

   assign in_cmd = {cmd.cmd_op, cmd.cmd_i_first, cmd.cmd_i_last,
                    cmd.cmd_j_first, cmd.cmd_j_last};
   assign head   = mem[rd_ptr];

   assign cmd.cmd_ready = !reset && (count != FULL);
   assign push          = cmd.cmd_valid && cmd.cmd_ready && !abort;

   assign head_ill   = head.op > 3'd4;
   assign head_empty = !head_ill &&
                       ((head.i_first > head.i_last) ||
                        (head.j_first > head.j_last));

   assign last_tile = (tp_tile_i == i_last_q) &&
                      (tp_tile_j == j_last_q);

   always_ff @(posedge clk) begin
      if (push) begin
         mem[wr_ptr] <= in_cmd;
      end
   end

   always_ff @(posedge clk) begin
      if (reset || abort) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) begin
            rd_ptr <= rd_ptr + 1'b1;
         end
         unique case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      pop       = 1'b0;
      pop_ill   = 1'b0;
      pop_empty = 1'b0;
      complete  = 1'b0;
      timeout   = 1'b0;
      unique case (state_q)
         IDLE: begin
            if (count != '0) begin
               pop = 1'b1;
               unique case (1'b1)
                  head_ill:   pop_ill   = 1'b1;
                  head_empty: pop_empty = 1'b1;
                  default:    state_d   = ISSUE;
               endcase
            end
         end
         ISSUE: state_d = WAIT;
         WAIT: begin
            // a done level already high on entry is not an edge
            if (tp_done && !done_q) begin
               complete = 1'b1;
               state_d  = NEXT;
            end else if (tcnt == TLAST) begin
               timeout = 1'b1;
               state_d = IDLE;
            end
         end
         NEXT:    state_d = last_tile ? IDLE : ISSUE;
         default: state_d = IDLE;
      endcase
      if (abort) begin
         state_d   = IDLE;
         pop       = 1'b0;
         pop_ill   = 1'b0;
         pop_empty = 1'b0;
         complete  = 1'b0;
         timeout   = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         done_q     <= 1'b0;
         tp_start   <= 1'b0;
         busy       <= 1'b0;
         cmd_done   <= 1'b0;
         err        <= 1'b0;
         err_code   <= 2'd0;
         tiles_done <= 7'd0;
         tp_op_code <= 3'd0;
         tp_tile_i  <= 3'd0;
         tp_tile_j  <= 3'd0;
         i_last_q   <= 3'd0;
         j_first_q  <= 3'd0;
         j_last_q   <= 3'd0;
         tcnt       <= '0;
      end else begin
         done_q   <= tp_done;
         tp_start <= (state_d == ISSUE);
         busy     <= (state_d != IDLE);
         cmd_done <= 1'b0;
         err      <= 1'b0;
         if (state_q == WAIT) begin
            tcnt <= tcnt + 1'b1;
         end
         if (pop) begin
            tiles_done <= 7'd0;
            err_code   <= 2'd0;
            tcnt       <= '0;
            unique case (1'b1)
               pop_ill: begin
                  err      <= 1'b1;
                  err_code <= 2'd1;
               end
               pop_empty: cmd_done <= 1'b1;
               default: begin
                  tp_op_code <= head.op;
                  tp_tile_i  <= head.i_first;
                  tp_tile_j  <= head.j_first;
                  i_last_q   <= head.i_last;
                  j_first_q  <= head.j_first;
                  j_last_q   <= head.j_last;
               end
            endcase
         end
         if (complete) begin
            tiles_done <= tiles_done + 7'd1;
            cmd_done   <= last_tile;
         end
         if (timeout) begin
            err      <= 1'b1;
            err_code <= 2'd2;
         end
         if ((state_q == NEXT) && !abort && !last_tile) begin
            tcnt <= '0;
            if (tp_tile_j < j_last_q) begin
               tp_tile_j <= tp_tile_j + 3'd1;
            end else begin
               tp_tile_i <= tp_tile_i + 3'd1;
               tp_tile_j <= j_first_q;
            end
         end
      end
   end

endmodule
